// File: rtl/pc_gen_if.sv
// pc_gen_if: bundle between decode/exception logic, pc_gen and fetch.
// slave = pc_gen side (drives pc/pc_valid/pc_adel/flush);
// master = environment side (drives fetch_ready, branch and trap inputs).
interface pc_gen_if;
   logic        fetch_ready;
   logic        br_valid;
   logic [31:0] br_pc;
   logic [2:0]  br_kind;
   logic        br_reg;
   logic [25:0] br_index;
   logic [15:0] br_offset;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        exc_valid;
   logic        eret_valid;
   logic [31:0] epc;
   logic [31:0] pc;
   logic        pc_valid;
   logic        pc_adel;
   logic        flush;

   modport slave (
      input  fetch_ready, br_valid, br_pc, br_kind, br_reg,
      input  br_index, br_offset, rs_data, rt_data,
      input  exc_valid, eret_valid, epc,
      output pc, pc_valid, pc_adel, flush
   );

   modport master (
      output fetch_ready, br_valid, br_pc, br_kind, br_reg,
      output br_index, br_offset, rs_data, rt_data,
      output exc_valid, eret_valid, epc,
      input  pc, pc_valid, pc_adel, flush
   );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: registered fetch PC with valid/ready handshake, branch/jump
// target resolution, exception/ERET redirect and a one-entry pending
// redirect buffer that holds a taken branch until its delay slot is
// accepted. Ports: clk, reset (async, active-high), bus (pc_gen_if.slave).
module pc_gen #(
   parameter logic [31:0] RESET_PC   = 32'hbfc0_0000,
   parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380,
   parameter bit          DELAY_SLOT = 1'b1
) (
   input logic     clk,
   input logic     reset,
   pc_gen_if.slave bus
);

   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        flush_q, flush_d;
   logic        pend_v_q, pend_v_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;

   logic        accept;
   logic        cond;
   logic        taken;
   logic [31:0] slot;
   logic [31:0] br_tgt;
   logic [31:0] tgt;
   logic [31:0] off_ext;

   assign accept  = valid_q & bus.fetch_ready;
   assign slot    = bus.br_pc + 32'd4;
   assign off_ext = {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
   assign br_tgt  = slot + off_ext;

   always_comb begin
      cond = 1'b0;
      case (bus.br_kind)
         3'b001:  cond = 1'b1;
         3'b010:  cond = (bus.rs_data == bus.rt_data);
         3'b011:  cond = (bus.rs_data != bus.rt_data);
         3'b100:  cond = ($signed(bus.rs_data) >  32'sd0);
         3'b101:  cond = ($signed(bus.rs_data) <  32'sd0);
         3'b110:  cond = ($signed(bus.rs_data) >= 32'sd0);
         3'b111:  cond = ($signed(bus.rs_data) <= 32'sd0);
         default: cond = 1'b0;
      endcase
   end

   always_comb begin
      tgt = br_tgt;
      if (bus.br_kind == 3'b001) begin
         tgt = bus.br_reg ? bus.rs_data
                          : {bus.br_pc[31:28], bus.br_index, 2'b00};
      end
   end

   assign taken = bus.br_valid & cond;

   always_comb begin
      pc_d       = pc_q;
      valid_d    = 1'b1;
      flush_d    = 1'b0;
      pend_v_d   = pend_v_q;
      pend_tgt_d = pend_tgt_q;
      if (bus.exc_valid) begin
         pc_d     = EXC_VECTOR;
         flush_d  = 1'b1;
         pend_v_d = 1'b0;
      end else if (bus.eret_valid) begin
         pc_d     = bus.epc;
         flush_d  = 1'b1;
         pend_v_d = 1'b0;
      end else if (taken) begin
         // Slot still waiting to be fetched: park the target until
         // the slot goes out; otherwise redirect straight away.
         if (DELAY_SLOT && (pc_q == slot) && !accept) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = tgt;
         end else begin
            pc_d     = tgt;
            flush_d  = 1'b1;
            pend_v_d = 1'b0;
         end
      end else if (pend_v_q && accept) begin
         // The held pc is the delay slot of the pending branch.
         pc_d     = pend_tgt_q;
         flush_d  = 1'b1;
         pend_v_d = 1'b0;
      end else if (accept) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         flush_q    <= 1'b0;
         pend_v_q   <= 1'b0;
         pend_tgt_q <= 32'd0;
      end else begin
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         flush_q    <= flush_d;
         pend_v_q   <= pend_v_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.pc_valid = valid_q;
   assign bus.flush    = flush_q;
   assign bus.pc_adel  = valid_q & (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenario tasks for pc_gen with hand-computed
// expected pc/flush/valid/adel values.
module tb_pc_gen;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   pc_gen_if bus ();

   pc_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_br();
      bus.br_valid   = 1'b0;
      bus.br_kind    = 3'b000;
      bus.br_reg     = 1'b0;
      bus.exc_valid  = 1'b0;
      bus.eret_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      clear_br();
      bus.fetch_ready = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic set_br(input logic [2:0] kind, input logic [31:0] bpc,
                         input logic [15:0] off, input logic [31:0] rs,
                         input logic [31:0] rt);
      bus.br_valid  = 1'b1;
      bus.br_kind   = kind;
      bus.br_pc     = bpc;
      bus.br_offset = off;
      bus.rs_data   = rs;
      bus.rt_data   = rt;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      tests_run++;
      if ({bus.pc, bus.pc_valid, bus.flush, bus.pc_adel} !==
          {32'hbfc00000, 1'b0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_state: pc=%h v=%b f=%b a=%b exp bfc00000 0 0 0",
                  bus.pc, bus.pc_valid, bus.flush, bus.pc_adel);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.fetch_ready = 1'b1;
      step();
      tests_run++;
      if ({bus.pc, bus.pc_valid, bus.flush} !== {32'hbfc00000, 2'b10}) begin
         tests_failed++;
         $display("FAIL first_valid: pc=%h v=%b f=%b exp bfc00000 1 0",
                  bus.pc, bus.pc_valid, bus.flush);
      end
      step();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00004, 1'b0}) begin
         tests_failed++;
         $display("FAIL seq_1: pc=%h f=%b exp bfc00004 0", bus.pc, bus.flush);
      end
      step();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00008, 1'b0}) begin
         tests_failed++;
         $display("FAIL seq_2: pc=%h f=%b exp bfc00008 0", bus.pc, bus.flush);
      end
   endtask

   task automatic test_branch_pending();
      do_reset();
      bus.fetch_ready = 1'b1;
      step();
      step();
      bus.fetch_ready = 1'b0;
      set_br(3'b010, 32'hbfc00000, 16'h0004, 32'd5, 32'd5);
      step();
      clear_br();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00004, 1'b0}) begin
         tests_failed++;
         $display("FAIL pend_hold0: pc=%h f=%b exp bfc00004 0", bus.pc, bus.flush);
      end
      step();
      step();
      tests_run++;
      if ({bus.pc, bus.pc_valid, bus.flush} !== {32'hbfc00004, 2'b10}) begin
         tests_failed++;
         $display("FAIL pend_hold2: pc=%h v=%b f=%b exp bfc00004 1 0",
                  bus.pc, bus.pc_valid, bus.flush);
      end
      bus.fetch_ready = 1'b1;
      step();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00014, 1'b1}) begin
         tests_failed++;
         $display("FAIL pend_apply: pc=%h f=%b exp bfc00014 1", bus.pc, bus.flush);
      end
      step();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00018, 1'b0}) begin
         tests_failed++;
         $display("FAIL pend_after: pc=%h f=%b exp bfc00018 0", bus.pc, bus.flush);
      end
   endtask

   task automatic test_not_taken();
      do_reset();
      bus.fetch_ready = 1'b1;
      step();
      step();
      set_br(3'b010, 32'hbfc00000, 16'h0004, 32'd5, 32'd6);
      step();
      clear_br();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00008, 1'b0}) begin
         tests_failed++;
         $display("FAIL beq_nt: pc=%h f=%b exp bfc00008 0", bus.pc, bus.flush);
      end
   endtask

   task automatic test_conditions();
      do_reset();
      bus.fetch_ready = 1'b1;
      step();
      step();
      set_br(3'b110, 32'hbfc00000, 16'h0004, 32'h80000000, 32'd0);
      step();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00008, 1'b0}) begin
         tests_failed++;
         $display("FAIL bgez_nt: pc=%h f=%b exp bfc00008 0", bus.pc, bus.flush);
      end
      set_br(3'b111, 32'hbfc00004, 16'h0010, 32'd0, 32'd0);
      step();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00048, 1'b1}) begin
         tests_failed++;
         $display("FAIL blez_t: pc=%h f=%b exp bfc00048 1", bus.pc, bus.flush);
      end
      set_br(3'b011, 32'hbfc00044, 16'hfffc, 32'd1, 32'd2);
      step();
      clear_br();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00038, 1'b1}) begin
         tests_failed++;
         $display("FAIL bne_neg: pc=%h f=%b exp bfc00038 1", bus.pc, bus.flush);
      end
      step();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc0003c, 1'b0}) begin
         tests_failed++;
         $display("FAIL bne_next: pc=%h f=%b exp bfc0003c 0", bus.pc, bus.flush);
      end
   endtask

   task automatic test_exc_priority();
      do_reset();
      bus.fetch_ready = 1'b1;
      step();
      step();
      bus.fetch_ready = 1'b0;
      set_br(3'b010, 32'hbfc00000, 16'h0004, 32'd5, 32'd5);
      step();
      set_br(3'b011, 32'hbfc00000, 16'h0008, 32'd1, 32'd2);
      bus.exc_valid = 1'b1;
      step();
      clear_br();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00380, 1'b1}) begin
         tests_failed++;
         $display("FAIL exc_redirect: pc=%h f=%b exp bfc00380 1", bus.pc, bus.flush);
      end
      bus.fetch_ready = 1'b1;
      step();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00384, 1'b0}) begin
         tests_failed++;
         $display("FAIL exc_nopend: pc=%h f=%b exp bfc00384 0", bus.pc, bus.flush);
      end
      step();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00388, 1'b0}) begin
         tests_failed++;
         $display("FAIL exc_seq: pc=%h f=%b exp bfc00388 0", bus.pc, bus.flush);
      end
   endtask

   task automatic test_jump_eret();
      bus.fetch_ready = 1'b0;
      set_br(3'b001, 32'hbfc00380, 16'h0000, 32'h80001002, 32'd0);
      bus.br_reg = 1'b1;
      step();
      clear_br();
      tests_run++;
      if ({bus.pc, bus.flush, bus.pc_adel} !== {32'h80001002, 2'b11}) begin
         tests_failed++;
         $display("FAIL jr_adel: pc=%h f=%b a=%b exp 80001002 1 1",
                  bus.pc, bus.flush, bus.pc_adel);
      end
      bus.eret_valid = 1'b1;
      bus.epc = 32'h80000100;
      step();
      clear_br();
      tests_run++;
      if ({bus.pc, bus.flush, bus.pc_adel} !== {32'h80000100, 2'b10}) begin
         tests_failed++;
         $display("FAIL eret: pc=%h f=%b a=%b exp 80000100 1 0",
                  bus.pc, bus.flush, bus.pc_adel);
      end
      set_br(3'b001, 32'hbfc00380, 16'h0000, 32'd0, 32'd0);
      bus.br_index = 26'h0000100;
      step();
      clear_br();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hb0000400, 1'b1}) begin
         tests_failed++;
         $display("FAIL j_target: pc=%h f=%b exp b0000400 1", bus.pc, bus.flush);
      end
      bus.exc_valid = 1'b1;
      bus.eret_valid = 1'b1;
      bus.epc = 32'h12345678;
      step();
      clear_br();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00380, 1'b1}) begin
         tests_failed++;
         $display("FAIL exc_over_eret: pc=%h f=%b exp bfc00380 1", bus.pc, bus.flush);
      end
      bus.eret_valid = 1'b1;
      bus.epc = 32'hfffffffc;
      step();
      clear_br();
      bus.fetch_ready = 1'b1;
      step();
      tests_run++;
      if ({bus.pc, bus.flush, bus.pc_adel} !== {32'h00000000, 2'b00}) begin
         tests_failed++;
         $display("FAIL wrap: pc=%h f=%b a=%b exp 00000000 0 0",
                  bus.pc, bus.flush, bus.pc_adel);
      end
   endtask

   task automatic test_reset_mid_pending();
      do_reset();
      bus.fetch_ready = 1'b1;
      step();
      step();
      bus.fetch_ready = 1'b0;
      set_br(3'b010, 32'hbfc00000, 16'h0004, 32'd7, 32'd7);
      step();
      clear_br();
      reset = 1'b1;
      #1;
      tests_run++;
      if ({bus.pc, bus.pc_valid, bus.flush} !== {32'hbfc00000, 2'b00}) begin
         tests_failed++;
         $display("FAIL mid_reset: pc=%h v=%b f=%b exp bfc00000 0 0",
                  bus.pc, bus.pc_valid, bus.flush);
      end
      #1;
      reset = 1'b0;
      bus.fetch_ready = 1'b1;
      step();
      step();
      step();
      tests_run++;
      if ({bus.pc, bus.flush} !== {32'hbfc00008, 1'b0}) begin
         tests_failed++;
         $display("FAIL pend_dropped: pc=%h f=%b exp bfc00008 0", bus.pc, bus.flush);
      end
   endtask

   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      reset           = 1'b1;
      bus.fetch_ready = 1'b0;
      bus.br_valid    = 1'b0;
      bus.br_pc       = 32'd0;
      bus.br_kind     = 3'b000;
      bus.br_reg      = 1'b0;
      bus.br_index    = 26'd0;
      bus.br_offset   = 16'd0;
      bus.rs_data     = 32'd0;
      bus.rt_data     = 32'd0;
      bus.exc_valid   = 1'b0;
      bus.eret_valid  = 1'b0;
      bus.epc         = 32'd0;
      test_reset();
      test_branch_pending();
      test_not_taken();
      test_conditions();
      test_exc_priority();
      test_jump_eret();
      test_reset_mid_pending();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-side PC generator that replaces the combinational next-PC logic with a registered PC, a valid/ready handshake to the fetch stage, and redirect control. Branch and jump targets are resolved here from operands supplied by decode, and MIPS delay-slot ordering is enforced through a one-entry pending-redirect buffer. Exception and ERET redirects are prioritised over branches, and misaligned targets are flagged. It sits between the decode and exception logic and the instruction-SRAM request port.

## Interface
- RESET_PC, 32'hbfc0_0000, PC loaded by reset
- EXC_VECTOR, 32'hbfc0_0380, exception entry address
- DELAY_SLOT, 1, 1 = MIPS branch delay slot honoured; 0 = redirect replaces the next sequential PC
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- fetch_ready  in  1  fetch accepts the presented PC this cycle
- br_valid  in  1  decode presents a resolved control-transfer instruction
- br_pc  in  32  PC of that instruction
- br_kind  in  3  000 none, 001 J/JAL, 010 BEQ, 011 BNE, 100 BGTZ, 101 BLTZ, 110 BGEZ, 111 BLEZ
- br_reg  in  1  with br_kind=001: JR/JALR, target = rs_data
- br_index  in  26  J-type index
- br_offset  in  16  branch offset
- rs_data, rt_data  in  32 each  compare operands
- exc_valid  in  1  exception committed
- eret_valid  in  1  ERET committed
- epc  in  32  return address for ERET
- pc  out  32  fetch address
- pc_valid  out  1  pc is a valid request
- pc_adel  out  1  current pc misaligned (pc[1:0]!=0)
- flush  out  1  one-cycle pulse: pc was just loaded from a redirect

## Operation
- Accept = pc_valid & fetch_ready. On accept with no redirect: pc <= pc+4.
- Targets:
  - J: {br_pc[31:28], br_index, 2'b00}.
  - JR: rs_data.
  - Branch: br_pc+4 + sign_ext(br_offset)<<2.
  - Branch conditions: rs==rt, rs!=rt, and $signed(rs) compared with 0 for >, <, >=, <=.
- Not-taken branch or br_kind=000: no redirect, no flush, pending state untouched.
- Priority when events coincide: exc_valid > eret_valid > branch.
  - exc_valid: pc <= EXC_VECTOR next cycle, regardless of fetch_ready; clears the pending buffer.
  - eret_valid: pc <= epc next cycle, same rules as exc_valid.
- Branch redirect, DELAY_SLOT=1, with slot = br_pc+4:
  - Slot still presented and not accepted this cycle (pc==slot, no accept): store target in the pending buffer.
  - Slot accepted this cycle: pc <= target next cycle.
  - pc already past the slot: pc <= target next cycle.
- Branch redirect, DELAY_SLOT=0: pc <= target next cycle.
- Pending buffer (one entry: valid + 32-bit target):
  - Applied on the cycle its delay slot is accepted; pc <= target next cycle.
  - A new taken branch overwrites it.
  - exc_valid or eret_valid clears it.
- Any redirect load pulses flush=1 for the single cycle in which the new pc is first presented.
- Misaligned targets are loaded unchanged; pc_adel=pc_valid&(pc[1:0]!=0). Fetch must not issue them; the exception path consumes pc_adel.
- Handshake: pc and pc_valid hold while not accepted, except when a redirect replaces an unaccepted pc.

## Timing
- Reset (async assert): pc=RESET_PC, pc_valid=0, flush=0, pc_adel=0, pending cleared.
- pc_valid rises on the first clock edge after reset deasserts.
- Redirect latency: event in cycle N; new pc and flush=1 in cycle N+1.
- Pending apply: delay slot accepted in cycle M; target presented in cycle M+1.
- Sequential throughput: one PC per cycle with fetch_ready held high.
- Reset asserted mid-stall or mid-pending: all state returns to reset values immediately; no pending redirect survives.
- PC+4 wraps modulo 2^32 (32'hfffffffc -> 0), no flag.

## Test plan
- Reset release, fetch_ready=1 -> pc 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles; flush=0 throughout.
- DELAY_SLOT=1; BEQ at 0xbfc00000, offset 0x0004, rs=rt=5, while pc=0xbfc00004 with fetch_ready=0 for 3 cycles -> pending held, pc stays 0xbfc00004; first cycle after accept -> pc=0xbfc00014, flush=1.
- Same BEQ with rs=5, rt=6 -> no flush, pc continues 0xbfc00008.
- BGEZ with rs=0x80000000 -> not taken; BLEZ with rs=0 -> taken.
- exc_valid and a taken branch in the same cycle, branch pending -> pc=0xbfc00380 next cycle, pending cleared, later slot acceptance causes no redirect.
- JR with rs_data=0x80001002 -> pc=0x80001002, flush=1, pc_adel=1; eret_valid with epc=0x80000100 -> pc=0x80000100, pc_adel=0.
